axis_burst_source: RTL and testbench

- AXI4-stream master-side traffic source that drives the slave port of the stream FIFO, and any other stream sink, with a programmed burst of incrementing data beats.
- On a start pulse it latches a start value and a beat count, then emits beats under valid/ready handshake rules.
- It flags the final beat and reports completion.
- It is used as the synthesizable producer in FIFO integration and hardware self-test.

---
 rtl/axis_burst_source.sv | 148 ++++++++++++++
 tb/tb_axis_burst_source.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_burst_source.sv
// Purpose: AXI4-stream burst source of incrementing beats; optional inter-beat gaps via AXIS_BURST_SOURCE_GAP_EN.
// Latency: first m_valid 1 cycle after start; done pulses 1 cycle after the final handshake.
// Backpressure: beats hold stable while m_ready is low; start is ignored (not queued) while busy.
module axis_burst_source #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16,
    parameter int STEP      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] start_value,
    input  logic [CNT_W-1:0]     beat_count,
`ifdef AXIS_BURST_SOURCE_GAP_EN
    input  logic [7:0]           gap_cycles,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t               state;
    state_t               state_n;
    logic [DATA_SIZE-1:0] data_reg;
    logic [DATA_SIZE-1:0] data_n;
    logic [CNT_W-1:0]     remaining;
    logic [CNT_W-1:0]     rem_n;
    logic                 accept;
    logic                 final_beat;
    logic                 valid_n;
    logic                 last_n;
    logic                 gap_clear;

`ifdef AXIS_BURST_SOURCE_GAP_EN
    logic [7:0]           gap_len;
    logic [7:0]           gap_len_n;
    logic [7:0]           gap_cnt;
    logic [7:0]           gap_n;
`endif

    assign accept     = m_valid && m_ready;
    assign final_beat = (remaining == CNT_W'(1));
    assign m_data     = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (beat_count == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (accept && final_beat) begin
                    state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next-cycle datapath and registered output values.
    always_comb begin
        data_n = data_reg;
        rem_n  = remaining;
`ifdef AXIS_BURST_SOURCE_GAP_EN
        gap_len_n = gap_len;
        gap_n     = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (start && (beat_count != '0)) begin
                    data_n = start_value;
                    rem_n  = beat_count;
`ifdef AXIS_BURST_SOURCE_GAP_EN
                    gap_len_n = gap_cycles;
                    gap_n     = 8'd0;
`endif
                end
            end
            SEND: begin
                if (accept) begin
                    data_n = data_reg + DATA_SIZE'(STEP);
                    rem_n  = remaining - CNT_W'(1);
`ifdef AXIS_BURST_SOURCE_GAP_EN
                    // No trailing gap after the final beat so done timing is unaffected.
                    gap_n = final_beat ? 8'd0 : gap_len;
`endif
                end
`ifdef AXIS_BURST_SOURCE_GAP_EN
                else if (gap_cnt != 8'd0) begin
                    gap_n = gap_cnt - 8'd1;
                end
`endif
            end
            default: ;
        endcase

`ifdef AXIS_BURST_SOURCE_GAP_EN
        gap_clear = (gap_n == 8'd0);
`else
        gap_clear = 1'b1;
`endif
        valid_n = (state_n == SEND) && gap_clear;
        last_n  = valid_n && (rem_n == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef AXIS_BURST_SOURCE_GAP_EN
            gap_len   <= 8'd0;
            gap_cnt   <= 8'd0;
`endif
        end else begin
            data_reg  <= data_n;
            remaining <= rem_n;
            m_valid   <= valid_n;
            m_last    <= last_n;
            busy      <= (state_n != IDLE);
            done      <= (state_n == FIN);
`ifdef AXIS_BURST_SOURCE_GAP_EN
            gap_len   <= gap_len_n;
            gap_cnt   <= gap_n;
`endif
        end
    end

endmodule

// File: tb/tb_axis_burst_source.sv
// Scoreboard bench for axis_burst_source: stimulus queues expected beats, a monitor pops on each handshake.
module tb_axis_burst_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_value = 8'h00;
    logic [15:0] beat_count = 16'h0;
    logic        m_ready = 1'b0;
`ifdef AXIS_BURST_SOURCE_GAP_EN
    logic [7:0]  gap_cycles = 8'd0;
`endif
    logic        busy;
    logic        done;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;

    always #5 clk = ~clk;

    axis_burst_source #(.DATA_SIZE(8), .CNT_W(16), .STEP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_value (start_value),
        .beat_count  (beat_count),
`ifdef AXIS_BURST_SOURCE_GAP_EN
        .gap_cycles  (gap_cycles),
`endif
        .busy        (busy),
        .done        (done),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          ready_mode = 2;
    int          pidx = 0;
    logic [19:0] pat = 20'b11111111_00000_1010110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: 0 = always ready, 1 = stall pattern, otherwise not ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = pat[pidx];
                    pidx = (pidx + 1) % 20;
                end
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each handshake against the scoreboard and checks stall stability.
    initial begin
        beat_t      e;
        bit         pending = 0;
        bit         last_seen = 0;
        int         last_cyc = 0;
        logic [7:0] held_data = 8'h00;
        logic       held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
            end else begin
                if (pending)
                    check("stall_hold", {23'd0, m_valid, m_last, m_data}, {23'd0, 1'b1, held_last, held_data});
                pending = 0;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_beat: got data %0h with no beat expected", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {23'd0, m_last, m_data}, {23'd0, e.l, e.d});
                        if (m_last) begin
                            last_seen = 1;
                            last_cyc  = cyc;
                        end
                    end
                end else if (m_valid) begin
                    pending   = 1;
                    held_data = m_data;
                    held_last = m_last;
                end
                if (done) begin
                    done_cnt++;
                    if (last_seen) begin
                        check("done_timing", cyc, last_cyc + 1);
                        last_seen = 0;
                    end
                end
            end
        end
    end

    task automatic expect_burst(input logic [7:0] sv, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = 8'(sv + i);
            b.l = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(input logic [7:0] sv, input logic [15:0] n, input logic [7:0] g);
        @(posedge clk);
        #1;
        start       = 1'b1;
        start_value = sv;
        beat_count  = n;
`ifdef AXIS_BURST_SOURCE_GAP_EN
        gap_cycles  = g;
`else
        if (g != 8'd0) $display("note: gap request %0d ignored in this build", g);
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int ncyc, output bit all_busy);
        bit fin = 0;
        ncyc     = 0;
        all_busy = 1;
        while (!fin) begin
            @(negedge clk);
            ncyc++;
            if (!busy) all_busy = 0;
            if (done) begin
                fin = 1;
            end else if (ncyc >= 300) begin
                checks++;
                $display("FAIL %s: timeout waiting for done", name);
                fin = 1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n;
        bit         b;
        int         dc;
        logic [6:0] vpat;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'd0, busy, done, m_valid, m_last, m_data}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 1 with an ignored start mid-burst.
        ready_mode = 0;
        expect_burst(8'h10, 4);
        do_start(8'h10, 16'd4, 8'd0);
        fork
            begin
                @(posedge clk);
                #1;
                start = 1'b1; start_value = 8'hAA; beat_count = 16'd9;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        wait_done("t1_done", n, b);
        check("t1_latency", n, 5);
        check("t1_busy", {31'd0, b}, 1);
        @(negedge clk);
        check("t1_idle", {29'd0, busy, done, m_valid}, 0);
        repeat (3) @(negedge clk);
        check("t1_no_requeue", {30'd0, busy, m_valid}, 0);

        // Test 2: wrap-around.
        expect_burst(8'hFE, 3);
        do_start(8'hFE, 16'd3, 8'd0);
        wait_done("t2_done", n, b);
        check("t2_latency", n, 4);

        // Test 3: stalls.
        pidx = 0;
        ready_mode = 1;
        dc = done_cnt;
        expect_burst(8'h20, 6);
        do_start(8'h20, 16'd6, 8'd0);
        wait_done("t3_done", n, b);
        check("t3_busy", {31'd0, b}, 1);
        repeat (3) @(negedge clk);
        check("t3_done_once", done_cnt - dc, 1);
        check("t3_all_beats", exp_q.size(), 0);

        // Test 4: zero-length burst.
        ready_mode = 0;
        do_start(8'h77, 16'd0, 8'd0);
        wait_done("t4_done", n, b);
        check("t4_latency", n, 1);
        check("t4_busy", {31'd0, b}, 1);
        check("t4_no_valid", {31'd0, m_valid}, 0);
        @(negedge clk);
        check("t4_idle", {30'd0, busy, done}, 0);

        // Test 5: reset mid-burst while stalled.
        expect_burst(8'h30, 8);
        do_start(8'h30, 16'd8, 8'd0);
        @(negedge clk);
        ready_mode = 2;
        @(negedge clk);
        check("t5_stalled_beat", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h31});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        dc = done_cnt;
        @(negedge clk);
        check("t5_after_rst", {29'd0, m_valid, busy, done}, 0);
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - dc, 0);
        ready_mode = 0;
        expect_burst(8'h40, 2);
        do_start(8'h40, 16'd2, 8'd0);
        wait_done("t5b_done", n, b);
        check("t5b_latency", n, 3);

`ifdef AXIS_BURST_SOURCE_GAP_EN
        // Test 6: inter-beat gaps.
        @(negedge clk);
        expect_burst(8'h50, 3);
        do_start(8'h50, 16'd3, 8'd2);
        vpat = 7'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vpat = {vpat[5:0], m_valid};
        end
        check("t6_valid_pattern", {25'd0, vpat}, 32'h49);
        @(negedge clk);
        check("t6_done", {31'd0, done}, 1);
`endif

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
